// File: rtl/mips_pkg.sv
// Shared widths, the zero-register constant and the writeback request type for the MIPS writeback stage.
package mips_pkg;

  localparam int REG_AW = 5;
  localparam int DATA_W = 32;

  typedef logic [REG_AW-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] data_t;

  localparam reg_addr_t ZERO_REG = '0;

  // One candidate register-file write: a load response, the held ALU result or a fresh ALU result.
  typedef struct packed {
    logic      vld;
    reg_addr_t dest;
    data_t     data;
  } wb_req_t;

  // Register 0 is hardwired, so a write aimed at it never reaches the register file.
  function automatic logic writes_reg(input wb_req_t r);
    return r.vld && (r.dest != ZERO_REG);
  endfunction

endpackage

// File: rtl/mips_wb_ldq.sv
// Pending-load destination FIFO with per-entry address match vectors for hazard detection.
// Zero latency on head; a push while full is dropped (even with a same-cycle pop), a pop while empty is ignored.
module mips_wb_ldq
  import mips_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic              push,
  input  logic [REG_AW-1:0] push_dest,
  input  logic              pop,
  input  logic [REG_AW-1:0] addr1,
  input  logic [REG_AW-1:0] addr2,
  output logic              full,
  output logic              empty,
  output logic [REG_AW-1:0] head,
  output logic [DEPTH-1:0]  match1,
  output logic [DEPTH-1:0]  match2
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);
  localparam logic [PW:0] ONE_CNT  = (PW+1)'(1);

  logic [REG_AW-1:0] dest_q [DEPTH];
  logic [DEPTH-1:0]  vld_q;
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [PW:0]       count;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = dest_q[rd_ptr];

  always_ff @(posedge CLK) begin
    if (rst) begin
      vld_q  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      // Pointers are power-of-two wide, so the increment wraps modulo DEPTH.
      if (do_push) begin
        vld_q[wr_ptr] <= 1'b1;
        wr_ptr        <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        vld_q[rd_ptr] <= 1'b0;
        rd_ptr        <= rd_ptr + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + ONE_CNT;
        2'b01:   count <= count - ONE_CNT;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push) dest_q[wr_ptr] <= push_dest;
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_match
    assign match1[i] = vld_q[i] && (dest_q[i] == addr1);
    assign match2[i] = vld_q[i] && (dest_q[i] == addr2);
  end

endmodule

// File: rtl/mips_writeback.sv
// MIPS writeback arbiter: load responses beat the held ALU result, which beats a fresh one; MIPS_WB_BYPASS_EN adds fwd outputs.
// Latency 1 (registered write port); alu_ready drops only while the one-entry skid buffer is occupied.
module mips_writeback
  import mips_pkg::*;
#(
  parameter int LD_DEPTH = 2
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [REG_AW-1:0] alu_dest,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              ld_issue,
  input  logic [REG_AW-1:0] ld_dest,
  output logic              ld_full,
  input  logic              mem_valid,
  input  logic [DATA_W-1:0] mem_data,
  output logic              RegWrite,
  output logic [REG_AW-1:0] WriteAddress,
  output logic [DATA_W-1:0] DataIn,
  input  logic [REG_AW-1:0] Address1,
  input  logic [REG_AW-1:0] Address2,
  output logic              hazard1,
  output logic              hazard2,
  output logic              ld_err
`ifdef MIPS_WB_BYPASS_EN
  ,
  output logic              fwd1,
  output logic              fwd2,
  output logic [DATA_W-1:0] fwd1_data,
  output logic [DATA_W-1:0] fwd2_data
`endif
);

  wb_req_t             skid_q;
  wb_req_t             win;
  logic                ldq_empty;
  logic [REG_AW-1:0]   ldq_head;
  logic [LD_DEPTH-1:0] ldq_match1;
  logic [LD_DEPTH-1:0] ldq_match2;
  logic                load_win;
  logic                alu_acc;
  logic                skid_load;
  logic                skid_drain;
  logic                wb_hit1;
  logic                wb_hit2;

  mips_wb_ldq #(
    .DEPTH(LD_DEPTH)
  ) u_ldq (
    .CLK      (CLK),
    .rst      (rst),
    .push     (ld_issue),
    .push_dest(ld_dest),
    .pop      (mem_valid),
    .addr1    (Address1),
    .addr2    (Address2),
    .full     (ld_full),
    .empty    (ldq_empty),
    .head     (ldq_head),
    .match1   (ldq_match1),
    .match2   (ldq_match2)
  );

  assign alu_ready = !skid_q.vld;
  assign alu_acc   = alu_valid && alu_ready;
  assign load_win  = mem_valid && !ldq_empty;

  // A fresh ALU result can only lose to a load: while the skid is full, alu_ready is low.
  always_comb begin
    win        = '0;
    skid_load  = 1'b0;
    skid_drain = 1'b0;
    if (load_win) begin
      win.vld   = 1'b1;
      win.dest  = ldq_head;
      win.data  = mem_data;
      skid_load = alu_acc;
    end else if (skid_q.vld) begin
      win        = skid_q;
      skid_drain = 1'b1;
    end else if (alu_acc) begin
      win = '{vld: 1'b1, dest: alu_dest, data: alu_data};
    end
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      skid_q <= '0;
    end else if (skid_load) begin
      skid_q <= '{vld: 1'b1, dest: alu_dest, data: alu_data};
    end else if (skid_drain) begin
      skid_q.vld <= 1'b0;
    end
  end

  // Address/data hold their last real write so a downstream reader never sees a register-0 write.
  always_ff @(posedge CLK) begin
    if (rst) begin
      RegWrite     <= 1'b0;
      WriteAddress <= '0;
      DataIn       <= '0;
    end else begin
      RegWrite <= writes_reg(win);
      if (writes_reg(win)) begin
        WriteAddress <= win.dest;
        DataIn       <= win.data;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      ld_err <= 1'b0;
    end else if (mem_valid && ldq_empty) begin
      ld_err <= 1'b1;
    end
  end

`ifdef MIPS_WB_BYPASS_EN
  // The in-flight write is forwarded instead of stalling the reader.
  assign fwd1      = RegWrite && (WriteAddress == Address1) && (Address1 != ZERO_REG);
  assign fwd2      = RegWrite && (WriteAddress == Address2) && (Address2 != ZERO_REG);
  assign fwd1_data = DataIn;
  assign fwd2_data = DataIn;
  assign wb_hit1   = 1'b0;
  assign wb_hit2   = 1'b0;
`else
  assign wb_hit1 = RegWrite && (WriteAddress == Address1);
  assign wb_hit2 = RegWrite && (WriteAddress == Address2);
`endif

  assign hazard1 = (Address1 != ZERO_REG) &&
                   ((|ldq_match1) || (skid_q.vld && (skid_q.dest == Address1)) || wb_hit1);
  assign hazard2 = (Address2 != ZERO_REG) &&
                   ((|ldq_match2) || (skid_q.vld && (skid_q.dest == Address2)) || wb_hit2);

endmodule

// File: doc/mips_writeback.md
MIPS_WRITEBACK -- requirements
Module: mips_writeback

Interface
REQ-001 SHALL provide parameter LD_DEPTH, default 2, giving the number of outstanding load destinations tracked (power of two, at least 2).
REQ-002 SHALL provide port CLK, input, 1, the system clock; all state updates on the rising edge.
REQ-003 SHALL provide port rst, input, 1, reset: synchronous, active-high.
REQ-004 SHALL provide ALU-side ports: alu_valid (input, 1), alu_ready (output, 1), alu_dest (input, 5), alu_data (input, 32).
REQ-005 SHALL provide load-issue ports: ld_issue (input, 1), ld_dest (input, 5), ld_full (output, 1).
REQ-006 SHALL provide memory-response ports: mem_valid (input, 1), mem_data (input, 32).
REQ-007 SHALL provide register-file write ports: RegWrite (output, 1), WriteAddress (output, 5), DataIn (output, 32).
REQ-008 SHALL provide hazard ports: Address1 and Address2 (input, 5); hazard1 and hazard2 (output, 1); ld_err (output, 1, sticky).

Function
REQ-009 SHALL keep a pending-load FIFO of LD_DEPTH 5-bit destinations; ld_full SHALL be high exactly when the count equals LD_DEPTH.
REQ-010 SHALL push ld_dest on ld_issue when not full; a push while full SHALL be dropped with count unchanged, even if a pop occurs in the same cycle.
REQ-011 SHALL pop the FIFO head on mem_valid; mem_valid with an empty FIFO SHALL be discarded and SHALL set ld_err.
REQ-012 SHALL accept an ALU result on alu_valid && alu_ready; alu_ready SHALL equal NOT(skid buffer full).
REQ-013 SHALL drive the write outputs from registers, one cycle after the winning event (latency 1).
REQ-014 SHALL use this write priority each cycle: load response, then skid buffer, then newly accepted ALU result.
REQ-015 SHALL store an accepted ALU result in the one-entry skid buffer when it loses arbitration; the skid buffer SHALL drain on the first cycle without a load response.
REQ-016 SHALL hold RegWrite low for any write whose destination is 0; the FIFO pop and the skid drain still occur.
REQ-017 SHALL assert RegWrite for exactly one cycle per non-zero write; when RegWrite is low, WriteAddress and DataIn SHALL hold their previous values.
REQ-018 SHALL assert hazardN combinationally when AddressN is non-zero and matches any of: a valid FIFO entry, the valid skid entry, or WriteAddress while RegWrite is high.
REQ-019 SHALL let a simultaneous push and pop (not full) leave the count unchanged, with the FIFO pointers wrapping modulo LD_DEPTH.

Reset
REQ-020 SHALL, while rst is high, empty the FIFO and the skid buffer, clear ld_err, and drive RegWrite=0, WriteAddress=0, DataIn=0.
REQ-021 SHALL drive alu_ready=1 and ld_full=0 in the cycle after reset.
REQ-022 SHALL discard pending loads on reset mid-operation; mem_valid seen after reset counts as a stray response per REQ-011.

Configuration
REQ-023 SHALL, with MIPS_WB_BYPASS_EN defined, add outputs fwd1 and fwd2 (1 bit each) and fwd1_data and fwd2_data (32 bits each).
REQ-024 SHALL, with MIPS_WB_BYPASS_EN defined, set fwdN = RegWrite && (WriteAddress == AddressN) && AddressN != 0, drive fwdN_data = DataIn, and drop the WriteAddress term from hazardN.
REQ-025 SHALL, without MIPS_WB_BYPASS_EN, omit the fwd ports entirely and keep hazardN exactly as in REQ-018.

Structure
REQ-026 SHALL place the register-address width (5), the data width (32) and the zero-register constant in the shared package mips_pkg.
REQ-027 SHALL implement the pending-load FIFO as the sub-module mips_wb_ldq, which exposes push, pop, full, empty, head and a per-entry match vector.

Verification
REQ-028 SHALL cover: ld_issue dest=5, then mem_valid data=0xDEADBEEF two cycles later -> RegWrite=1, WriteAddress=5, DataIn=0xDEADBEEF in the next cycle; hazard1 high for Address1=5 until that write.
REQ-029 SHALL cover: a same-cycle mem_valid (dest 3, 0x11) and ALU write (dest 4, 0x22) -> dest 3 written at cycle+1, dest 4 at cycle+2, alu_ready=0 during cycle+1.
REQ-030 SHALL cover: three ld_issue pulses with LD_DEPTH=2 -> the third is dropped, ld_full=1, and exactly two writes occur after two mem_valid pulses.
REQ-031 SHALL cover: ALU write to dest 0 with data 0xFFFFFFFF -> RegWrite stays 0, and hazard1 stays 0 for Address1=0.
REQ-032 SHALL cover: mem_valid with an empty FIFO -> no write and ld_err=1; a following rst -> ld_err=0.
REQ-033 SHALL cover, with MIPS_WB_BYPASS_EN: a write of dest 7, 0x1234 with Address2=7 -> fwd2=1, fwd2_data=0x1234, hazard2=0.
